// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares the single write port of a synchronous FIFO among
// NUM_REQ valid/ready requesters, with full/almostfull throttling and ack checking.
module fifo_wr_arbiter #(
  parameter int FIFO_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int CNT_W      = 16,
  localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  input  logic                          fifo_almostfull,
  input  logic                          fifo_wr_ack,
  input  logic                          fifo_overflow,
  output logic                          fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]         fifo_data_in,
  output logic [ID_W-1:0]               grant_id,
  output logic [CNT_W-1:0]              wr_count,
  output logic                          err_sticky
);

  logic                  r_wr_en;
  logic [FIFO_WIDTH-1:0] r_data;
  logic [ID_W-1:0]       r_grant_id;
  logic [ID_W-1:0]       r_rr_ptr;
  logic [CNT_W-1:0]      r_wr_count;
  logic                  r_err_sticky;
  logic                  r_ack_pending;

  logic                  w_can_issue;
  logic                  w_found;
  logic [ID_W-1:0]       w_gnt;
  logic [NUM_REQ-1:0]    w_ready;
  logic                  w_xfer;
  int                    w_idx;

  // A write already in flight will consume the last free slot, so almostfull must block too.
  assign w_can_issue = !fifo_full && !(fifo_almostfull && r_wr_en);

  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment so no latch is inferred.
    w_found = 1'b0;
    w_gnt   = '0;
    w_ready = '0;
    w_idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = (int'(r_rr_ptr) + k) % NUM_REQ;
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_gnt   = ID_W'(w_idx);
      end
    end
    if (rst_n && w_can_issue && w_found) begin
      w_ready[w_gnt] = 1'b1;
    end
  end

  assign w_xfer    = |w_ready;
  assign req_ready = w_ready;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rst_n) begin
      r_wr_en       <= 1'b0;
      r_data        <= '0;
      r_grant_id    <= '0;
      r_rr_ptr      <= '0;
      r_wr_count    <= '0;
      r_err_sticky  <= 1'b0;
      r_ack_pending <= 1'b0;
    end else begin
      r_wr_en       <= w_xfer;
      r_ack_pending <= r_wr_en;
      if (w_xfer) begin
        r_data     <= req_data[int'(w_gnt)*FIFO_WIDTH +: FIFO_WIDTH];
        r_grant_id <= w_gnt;
        r_rr_ptr   <= (w_gnt == ID_W'(NUM_REQ-1)) ? '0 : w_gnt + 1'b1;
      end
      if ((r_ack_pending && !fifo_wr_ack) || fifo_overflow) begin
        r_err_sticky <= 1'b1;
      end
      if (fifo_wr_ack && (r_wr_count != '1)) begin
        r_wr_count <= r_wr_count + 1'b1;
      end
    end
  end

  assign fifo_wr_en   = r_wr_en;
  assign fifo_data_in = r_data;
  assign grant_id     = r_grant_id;
  assign wr_count     = r_wr_count;
  assign err_sticky   = r_err_sticky;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter driving a small depth-8 FIFO model for full/ack/overflow.
module tb_fifo_wr_arbiter;

  localparam int W     = 16;
  localparam int N     = 4;
  localparam int DEPTH = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow;
  logic           fifo_wr_en;
  logic [W-1:0]   fifo_data_in;
  logic [1:0]     grant_id;
  logic [15:0]    wr_count;
  logic           err_sticky;

  int  n_pass = 0;
  int  n_total = 0;

  // FIFO model state and fault injection controls
  int   m_cnt;
  logic m_ack, m_ovf;
  logic nack_inj, ovf_inj;
  int   ovf_seen;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.FIFO_WIDTH(W), .NUM_REQ(N), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_almostfull(fifo_almostfull),
    .fifo_wr_ack(fifo_wr_ack), .fifo_overflow(fifo_overflow), .fifo_wr_en(fifo_wr_en),
    .fifo_data_in(fifo_data_in), .grant_id(grant_id), .wr_count(wr_count),
    .err_sticky(err_sticky)
  );

  always @(posedge clk) begin
    if (!rst_n) begin
      m_cnt <= 0;
      m_ack <= 1'b0;
      m_ovf <= 1'b0;
    end else begin
      m_ack <= 1'b0;
      m_ovf <= 1'b0;
      if (fifo_wr_en) begin
        if (m_cnt < DEPTH) begin
          m_cnt <= m_cnt + 1;
          m_ack <= 1'b1;
        end else begin
          m_ovf <= 1'b1;
        end
      end
    end
  end

  assign fifo_full       = (m_cnt == DEPTH);
  assign fifo_almostfull = (m_cnt == DEPTH-1);
  assign fifo_wr_ack     = m_ack && !nack_inj;
  assign fifo_overflow   = m_ovf || ovf_inj;

  always @(negedge clk) if (m_ovf) ovf_seen++;

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    nack_inj  = 1'b0;
    ovf_inj   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = 4'hF;
    repeat (3) @(negedge clk);
    #1;
    n_total++; if (req_ready !== 4'b0000) $display("FAIL reset_ready got=%b exp=0000", req_ready); else n_pass++;
    n_total++; if (fifo_wr_en !== 1'b0) $display("FAIL reset_wr_en got=%b exp=0", fifo_wr_en); else n_pass++;
    n_total++; if (wr_count !== 16'd0) $display("FAIL reset_wr_count got=%0d exp=0", wr_count); else n_pass++;
    n_total++; if (err_sticky !== 1'b0) $display("FAIL reset_err got=%b exp=0", err_sticky); else n_pass++;
    n_total++; if (fifo_data_in !== 16'h0 || grant_id !== 2'd0)
      $display("FAIL reset_data_gid got=%h/%0d exp=0000/0", fifo_data_in, grant_id); else n_pass++;
    rst_n = 1'b1;
    req_valid = '0;
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_rdy;
    int g;
    do_reset();
    @(negedge clk);
    req_valid = 4'hF;
    for (int i = 0; i < 6; i++) begin
      g = i % N;
      exp_rdy = 4'b0001 << g;
      #1;
      n_total++; if (req_ready !== exp_rdy) $display("FAIL rr_ready[%0d] got=%b exp=%b", i, req_ready, exp_rdy); else n_pass++;
      @(negedge clk);
      n_total++; if (fifo_wr_en !== 1'b1 || grant_id !== 2'(g) || fifo_data_in !== (16'hA000 | 16'(g << 4)))
        $display("FAIL rr_out[%0d] got=%b/%0d/%h exp=1/%0d/%h", i, fifo_wr_en, grant_id, fifo_data_in, g, 16'hA000 | 16'(g << 4));
      else n_pass++;
    end
    req_valid = '0;
  endtask

  task automatic test_sparse();
    int exp_g [6] = '{2, 2, 3, 1, 3, 1};
    do_reset();
    @(negedge clk);
    req_valid = 4'b0100;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) req_valid = 4'b1010;
      #1;
      n_total++; if (req_ready !== (4'b0001 << exp_g[i])) $display("FAIL sparse_ready[%0d] got=%b exp_gnt=%0d", i, req_ready, exp_g[i]); else n_pass++;
      @(negedge clk);
      n_total++; if (fifo_wr_en !== 1'b1 || grant_id !== 2'(exp_g[i]))
        $display("FAIL sparse_gid[%0d] got=%b/%0d exp=1/%0d", i, fifo_wr_en, grant_id, exp_g[i]); else n_pass++;
    end
    req_valid = '0;
  endtask

  task automatic test_full_throttle();
    int pulses = 0;
    do_reset();
    ovf_seen = 0;
    @(negedge clk);
    req_valid = 4'hF;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fifo_wr_en) pulses++;
    end
    n_total++; if (pulses !== 8) $display("FAIL full_pulses got=%0d exp=8", pulses); else n_pass++;
    n_total++; if (fifo_wr_en !== 1'b0) $display("FAIL full_wr_en_idle got=%b exp=0", fifo_wr_en); else n_pass++;
    n_total++; if (ovf_seen !== 0) $display("FAIL full_overflow got=%0d exp=0", ovf_seen); else n_pass++;
    n_total++; if (wr_count !== 16'd8) $display("FAIL full_wr_count got=%0d exp=8", wr_count); else n_pass++;
    n_total++; if (err_sticky !== 1'b0) $display("FAIL full_err got=%b exp=0", err_sticky); else n_pass++;
    #1;
    n_total++; if (req_ready !== 4'b0000) $display("FAIL full_ready got=%b exp=0000", req_ready); else n_pass++;
    req_valid = '0;
  endtask

  task automatic test_fault();
    do_reset();
    @(negedge clk);
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = '0;
    n_total++; if (fifo_wr_en !== 1'b1) $display("FAIL fault_wr_en got=%b exp=1", fifo_wr_en); else n_pass++;
    @(negedge clk);
    nack_inj = 1'b1;
    n_total++; if (err_sticky !== 1'b0) $display("FAIL fault_err_early got=%b exp=0", err_sticky); else n_pass++;
    @(negedge clk);
    nack_inj = 1'b0;
    n_total++; if (err_sticky !== 1'b1) $display("FAIL fault_nack_err got=%b exp=1", err_sticky); else n_pass++;
    repeat (4) @(negedge clk);
    n_total++; if (err_sticky !== 1'b1) $display("FAIL fault_err_held got=%b exp=1", err_sticky); else n_pass++;
    n_total++; if (wr_count !== 16'd0) $display("FAIL fault_wr_count got=%0d exp=0", wr_count); else n_pass++;
    do_reset();
    @(negedge clk);
    n_total++; if (err_sticky !== 1'b0) $display("FAIL fault_err_cleared got=%b exp=0", err_sticky); else n_pass++;
    ovf_inj = 1'b1;
    @(negedge clk);
    ovf_inj = 1'b0;
    n_total++; if (err_sticky !== 1'b1) $display("FAIL fault_ovf_err got=%b exp=1", err_sticky); else n_pass++;
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    @(negedge clk);
    req_valid = 4'hF;
    repeat (2) @(negedge clk);
    n_total++; if (fifo_wr_en !== 1'b1 || grant_id !== 2'd1)
      $display("FAIL midrst_pre got=%b/%0d exp=1/1", fifo_wr_en, grant_id); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++; if (req_ready !== 4'b0000) $display("FAIL midrst_ready got=%b exp=0000", req_ready); else n_pass++;
    @(negedge clk);
    n_total++; if (fifo_wr_en !== 1'b0) $display("FAIL midrst_wr_en got=%b exp=0", fifo_wr_en); else n_pass++;
    rst_n = 1'b1;
    #1;
    n_total++; if (req_ready !== 4'b0001) $display("FAIL midrst_first_ready got=%b exp=0001", req_ready); else n_pass++;
    @(negedge clk);
    n_total++; if (fifo_wr_en !== 1'b1 || grant_id !== 2'd0 || fifo_data_in !== 16'hA000)
      $display("FAIL midrst_first_gnt got=%b/%0d/%h exp=1/0/a000", fifo_wr_en, grant_id, fifo_data_in); else n_pass++;
    req_valid = '0;
    repeat (3) @(negedge clk);
    n_total++; if (err_sticky !== 1'b0) $display("FAIL midrst_err got=%b exp=0", err_sticky); else n_pass++;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    nack_inj  = 1'b0;
    ovf_inj   = 1'b0;
    ovf_seen  = 0;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = 16'hA000 | 16'(i << 4);
    test_reset();
    test_round_robin();
    test_sparse();
    test_full_throttle();
    test_fault();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
